// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that shares the async FIFO write port among
// NUM_REQ write-domain requesters over valid/ready handshakes.
// Build option: define FIFO_WR_ARB_PKT_LOCK_EN to keep multi-word packets
// contiguous. Without it, every accepted word rotates priority.
module fifo_wr_arb #(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 8,
    localparam int unsigned IDW        = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [IDW-1:0]                grant_id,
    output logic                          locked
);

    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW:0]   sum;
    logic           found;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e         state_q;
    logic [IDW-1:0] lock_id_q;
    logic           locked_q;
`endif

    // Pick the first valid requester at or after ptr; a held packet overrides the scan
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                sel   = sum[IDW-1:0];
            end
        end
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        if (state_q == StLock) begin
            sel = lock_id_q;
        end
`endif
    end

    // Same-cycle handshake and write-port mux; reset forces everything quiet
    always_comb begin
        req_ready = '0;
        wdata     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (sel == IDW'(i)) & req_valid[i] & ~wfull & wrst_n;
        end
        winc = |(req_valid & req_ready);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winc && sel == IDW'(i)) begin
                wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_nxt  = (sel == LAST_ID) ? '0 : sel + 1'b1;
    assign grant_id = wrst_n ? sel : '0;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    // Lock FSM: a non-last word opens a packet, the last word releases it and rotates
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ptr_q     <= '0;
            state_q   <= StIdle;
            lock_id_q <= '0;
            locked_q  <= 1'b0;
        end else if (winc) begin
            case (state_q)
                StIdle: begin
                    if (!req_last[sel]) begin
                        state_q   <= StLock;
                        lock_id_q <= sel;
                        locked_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_nxt;
                    end
                end
                StLock: begin
                    if (req_last[sel]) begin
                        state_q  <= StIdle;
                        ptr_q    <= ptr_nxt;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked = locked_q;
`else
    logic unused_last;

    // Per-word rotation: the requester after the one just served gets top priority
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ptr_q <= '0;
        end else if (winc) begin
            ptr_q <= ptr_nxt;
        end
    end

    assign unused_last = ^req_last;
    assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus constrained-random traffic, checked
// cycle by cycle against a distance-based round-robin reference model.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            wclk = 1'b0;
    logic            wrst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic            wfull;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [1:0]      grant_id;
    logic            locked;
    logic [DW-1:0]   dat [N];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_ptr     = 0;
    bit m_lock    = 0;
    int m_lock_id = 0;
    int acc_idx   = -1;

    // Last observed values, for scenario-level checks
    logic          obs_winc;
    logic [DW-1:0] obs_wdata;
    logic [1:0]    obs_gid;
    logic          obs_locked;

    fifo_wr_arb #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    always #5 wclk = ~wclk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = dat[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        req_valid = v;
        req_last  = l;
        wfull     = f;
    endtask

    // One clock: predict, sample on the falling edge, advance the model
    task automatic step();
        int e_sel;
        int best_d;
        int d;
        bit e_acc;
        if (m_lock) begin
            e_sel = m_lock_id;
        end else begin
            e_sel  = m_ptr;
            best_d = N;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    d = (i - m_ptr + N) % N;
                    if (d < best_d) begin
                        best_d = d;
                        e_sel  = i;
                    end
                end
            end
        end
        e_acc = req_valid[e_sel] && !wfull;
        @(negedge wclk);
        check("winc", 32'(winc), 32'(e_acc));
        check("req_ready", 32'(req_ready), e_acc ? (32'd1 << e_sel) : 32'd0);
        check("wdata", 32'(wdata), e_acc ? 32'(dat[e_sel]) : 32'd0);
        check("grant_id", 32'(grant_id), 32'(e_sel));
        check("locked", 32'(locked), 32'(m_lock));
        obs_winc   = winc;
        obs_wdata  = wdata;
        obs_gid    = grant_id;
        obs_locked = locked;
        acc_idx    = e_acc ? e_sel : -1;
        if (e_acc) begin
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
            if (m_lock) begin
                if (req_last[e_sel]) begin
                    m_lock = 0;
                    m_ptr  = (e_sel + 1) % N;
                end
            end else if (!req_last[e_sel]) begin
                m_lock    = 1;
                m_lock_id = e_sel;
            end else begin
                m_ptr = (e_sel + 1) % N;
            end
`else
            m_ptr = (e_sel + 1) % N;
`endif
        end
        @(posedge wclk);
        #1;
    endtask

    // Asynchronous reset: outputs must go quiet immediately, even with valids high
    task automatic do_reset();
        wrst_n = 1'b0;
        #1;
        check("rst_winc", 32'(winc), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        m_ptr     = 0;
        m_lock    = 0;
        m_lock_id = 0;
        acc_idx   = -1;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        drive('0, '1, 1'b0);
        for (int i = 0; i < N; i++) dat[i] = 8'hA0 + 8'(i);
        do_reset();

        // All four valid: strict rotation, one word per cycle
        drive(4'hF, 4'hF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("seq_winc", 32'(obs_winc), 32'd1);
            check("seq_wdata", 32'(obs_wdata), 32'(8'hA0 + 8'(k % 4)));
        end

        // Wrap-around from requester 3 back to 0
        drive(4'b1000, 4'hF, 1'b0);
        step();
        check("wrap_g3", 32'(obs_gid), 32'd3);
        drive(4'b1001, 4'hF, 1'b0);
        step();
        check("wrap_g0", 32'(obs_gid), 32'd0);
        step();
        check("wrap_then3", 32'(obs_gid), 32'd3);

        // FIFO full stalls everything without moving priority
        drive(4'b0110, 4'hF, 1'b1);
        repeat (5) begin
            step();
            check("full_winc", 32'(obs_winc), 32'd0);
            check("full_gid", 32'(obs_gid), 32'd1);
        end
        wfull = 1'b0;
        step();
        check("resume_gid", 32'(obs_gid), 32'd1);
        check("resume_wdata", 32'(obs_wdata), 32'hA1);

        // Random traffic honouring the hold-until-accepted contract
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == acc_idx) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_last[i]  = ($urandom_range(0, 1) == 1);
                    dat[i]       = 8'($urandom);
                end
            end
            wfull = ($urandom_range(0, 3) == 0);
            step();
        end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        // Three-word packet from requester 1 while requester 2 waits
        do_reset();
        for (int i = 0; i < N; i++) dat[i] = 8'h10 * 8'(i + 1);
        drive(4'b0110, 4'b0100, 1'b0);
        step();
        check("pkt_w1_gid", 32'(obs_gid), 32'd1);
        step();
        check("pkt_w2_gid", 32'(obs_gid), 32'd1);
        check("pkt_w2_locked", 32'(obs_locked), 32'd1);
        drive(4'b0110, 4'b0110, 1'b0);
        step();
        check("pkt_w3_gid", 32'(obs_gid), 32'd1);
        check("pkt_w3_locked", 32'(obs_locked), 32'd1);
        drive(4'b0100, 4'b0110, 1'b0);
        step();
        check("pkt_next_gid", 32'(obs_gid), 32'd2);
        drive(4'b0000, 4'b0110, 1'b0);
        step();
        check("pkt_ptr", 32'(obs_gid), 32'd3);

        // Owner drops valid mid-packet: nobody else is served
        do_reset();
        drive(4'b0010, 4'b0000, 1'b0);
        step();
        check("gap_open_gid", 32'(obs_gid), 32'd1);
        drive(4'b0101, 4'b0000, 1'b0);
        repeat (2) begin
            step();
            check("gap_winc", 32'(obs_winc), 32'd0);
            check("gap_locked", 32'(obs_locked), 32'd1);
        end
        drive(4'b0111, 4'b0000, 1'b0);
        step();
        check("gap_resume_gid", 32'(obs_gid), 32'd1);
        check("gap_resume_winc", 32'(obs_winc), 32'd1);
        do_reset();
        drive(4'b0000, 4'b1111, 1'b0);
        step();
        check("rst_ptr", 32'(obs_gid), 32'd0);
        drive(4'b1100, 4'b1111, 1'b0);
        step();
        check("rst_first_gid", 32'(obs_gid), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
